empire_result_acc: RTL and testbench



---
 rtl/empire_pkg.sv | 17 +
 rtl/empire_result_acc.sv | 114 +++++++++++
 tb/tb_empire_result_acc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/empire_pkg.sv
// Shared types and sizing helpers for the empire result path.
package empire_pkg;

    localparam int EMPIRE_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2
    } empire_acc_state_t;

    // Wide enough that a full block of all-ones samples cannot wrap.
    function automatic int acc_width(input int data_w, input int len);
        return data_w + $clog2(len);
    endfunction

endpackage

// File: rtl/empire_result_acc.sv
// Block accumulator: sums BLOCK_LEN unsigned samples and tracks their max, emitting {sum, max}.
// Latency: out_valid rises the cycle after the final sample of a block is accepted.
// Backpressure: in_ready drops only while a completed block is held by out_ready low.
module empire_result_acc
    import empire_pkg::*;
#(
    parameter int DATA_W    = EMPIRE_DATA_W,
    parameter int BLOCK_LEN = 8,
    parameter int ACC_W     = acc_width(DATA_W, BLOCK_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    input  logic              out_ready
);

    localparam int               CNT_W    = $clog2(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    empire_acc_state_t r_state;
    empire_acc_state_t w_state_nxt;

    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_max;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_out_sum;
    logic [DATA_W-1:0] r_out_max;

    logic [ACC_W-1:0]  w_acc_nxt;
    logic [DATA_W-1:0] w_max_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ACC_W-1:0]  w_sum_upd;
    logic [DATA_W-1:0] w_max_upd;
    logic              w_out_vld;
    logic              w_accept;
    logic              w_last;

    assign w_out_vld = (r_state == FULL);
    assign in_ready  = !(w_out_vld && !out_ready);
    assign w_accept  = in_valid && in_ready;
    // A sample taken in a clear cycle is dropped, so it can never close a block.
    assign w_last    = w_accept && !clear && (r_cnt == LAST_CNT);

    assign w_sum_upd = r_acc + ACC_W'(in_data);
    assign w_max_upd = (in_data > r_max) ? in_data : r_max;

    always_comb begin
        w_acc_nxt = r_acc;
        w_max_nxt = r_max;
        w_cnt_nxt = r_cnt;
        if (clear || w_last) begin
            w_acc_nxt = '0;
            w_max_nxt = '0;
            w_cnt_nxt = '0;
        end else if (w_accept) begin
            w_acc_nxt = w_sum_upd;
            w_max_nxt = w_max_upd;
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_last || (w_out_vld && !out_ready)) begin
            w_state_nxt = FULL;
        end else if (w_cnt_nxt != '0) begin
            w_state_nxt = ACCUM;
        end else begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_max <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            r_max <= w_max_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Output registers only move on a completion; a plain drain leaves them holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum <= '0;
            r_out_max <= '0;
        end else if (w_last) begin
            r_out_sum <= w_sum_upd;
            r_out_max <= w_max_upd;
        end
    end

    assign out_valid = w_out_vld;
    assign out_sum   = r_out_sum;
    assign out_max   = r_out_max;

endmodule

// File: tb/tb_empire_result_acc.sv
// Self-checking bench for empire_result_acc with BLOCK_LEN=4.
module tb_empire_result_acc;
    import empire_pkg::*;

    localparam int DW = 64;
    localparam int BL = 4;
    localparam int AW = acc_width(DW, BL);

    localparam logic [DW-1:0] ONES   = {DW{1'b1}};
    localparam logic [AW-1:0] SUM_F4 = 66'h3_FFFF_FFFF_FFFF_FFFC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          clear = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out_sum;
    logic [DW-1:0] out_max;
    logic          out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    empire_result_acc #(.DATA_W(DW), .BLOCK_LEN(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          c;
        logic          r;
        logic          e_rdy;
        logic          e_ov;
        logic [AW-1:0] e_sum;
        logic [DW-1:0] e_max;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic e_rdy, input logic e_ov,
                           input logic [AW-1:0] e_sum, input logic [DW-1:0] e_max);
        chk({name, ".in_ready"},  128'(in_ready),  128'(e_rdy));
        chk({name, ".out_valid"}, 128'(out_valid), 128'(e_ov));
        chk({name, ".out_sum"},   128'(out_sum),   128'(e_sum));
        chk({name, ".out_max"},   128'(out_max),   128'(e_max));
    endtask

    // Inputs change on the falling edge; outputs are inspected 1ns later.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic c, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clear     = c;
        out_ready = r;
        #1;
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d, input logic c, input logic r,
                       input logic e_rdy, input logic e_ov, input logic [AW-1:0] e_sum,
                       input logic [DW-1:0] e_max);
        vec_t x;
        x.v = v; x.d = d; x.c = c; x.r = r;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_sum = e_sum; x.e_max = e_max;
        tbl.push_back(x);
    endtask

    logic [DW-1:0] seq5[10];
    logic          m_valid;
    logic [AW-1:0] m_sum;
    logic [DW-1:0] m_max;
    logic [DW-1:0] blk[$];

    initial begin
        // Block 1,2,3,4 then an all-ones block.
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(1, 2, 0, 1, 1, 0, 0, 0);
        add(1, 3, 0, 1, 1, 0, 0, 0);
        add(1, 4, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 10, 4);
        add(0, 0, 0, 1, 1, 0, 10, 4);
        for (int i = 0; i < 4; i++) add(1, ONES, 0, 1, 1, 0, 10, 4);
        add(0, 0, 0, 1, 1, 1, SUM_F4, ONES);
        add(0, 0, 0, 1, 1, 0, SUM_F4, ONES);
        // 7, 9 and the sample offered with clear are all discarded.
        add(1, 7,   0, 1, 1, 0, SUM_F4, ONES);
        add(1, 9,   0, 1, 1, 0, SUM_F4, ONES);
        add(1, 100, 1, 1, 1, 0, SUM_F4, ONES);
        add(1, 2,   0, 1, 1, 0, SUM_F4, ONES);
        add(1, 3,   0, 1, 1, 0, SUM_F4, ONES);
        add(1, 4,   0, 1, 1, 0, SUM_F4, ONES);
        add(1, 6,   0, 1, 1, 0, SUM_F4, ONES);
        add(0, 0,   0, 1, 1, 1, 15, 6);
        add(0, 0,   0, 1, 1, 0, 15, 6);

        #2;
        chk_out("reset", 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
            chk_out($sformatf("tbl[%0d]", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_sum, tbl[i].e_max);
        end

        // Stalled output: in_ready falls while 20/5 is held, then both blocks drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 0, 0);
            chk_out($sformatf("stall_fill[%0d]", i), 1'b1, 1'b0, 15, 6);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            chk_out($sformatf("stall_hold[%0d]", i), 1'b0, 1'b1, 20, 5);
        end
        drive(1, 1, 0, 1);
        chk_out("stall_drain", 1'b1, 1'b1, 20, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1);
            chk_out($sformatf("stall_b2[%0d]", i), 1'b1, 1'b0, 20, 5);
        end
        drive(0, 0, 0, 1);
        chk_out("stall_beat2", 1'b1, 1'b1, 4, 1);
        drive(0, 0, 0, 1);
        chk_out("stall_done", 1'b1, 1'b0, 4, 1);

        // Back-to-back blocks with out_ready held high.
        seq5 = '{10, 20, 30, 40, 1, 2, 3, 100, 0, 0};
        for (int k = 0; k < 10; k++) begin
            drive(k < 8, seq5[k], 0, 1);
            if (k == 4)
                chk_out("b2b_a", 1'b1, 1'b1, 100, 40);
            else if (k >= 8)
                chk_out($sformatf("b2b_b[%0d]", k), 1'b1, k == 8, 106, 100);
            else
                chk(
                    $sformatf("b2b[%0d].in_ready+out_valid", k),
                    128'({in_ready, out_valid}), 128'(2'b10));
        end

        // Asynchronous reset mid-block (two samples in).
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_out("rst_midblock", 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1);
            chk_out($sformatf("post_rst1[%0d]", i), 1'b1, 1'b0, '0, '0);
        end
        drive(0, 0, 0, 1);
        chk_out("post_rst1_beat", 1'b1, 1'b1, 4, 1);

        // Asynchronous reset while a completed block is stalled.
        for (int i = 0; i < 4; i++) drive(1, 9, 0, 0);
        drive(0, 0, 0, 0);
        chk_out("stall_before_rst", 1'b0, 1'b1, 36, 9);
        #2 rst_n = 1'b0;
        #1 chk_out("rst_stalled", 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
        drive(0, 0, 0, 1);
        chk_out("post_rst2_beat", 1'b1, 1'b1, 4, 1);
        drive(0, 0, 0, 1);
        chk_out("post_rst2_idle", 1'b1, 1'b0, 4, 1);

        // Randomized traffic against a block-level reference model.
        m_valid = 1'b0;
        m_sum   = 4;
        m_max   = 1;
        blk.delete();
        for (int n = 0; n < 2000; n++) begin
            logic          v, c, r, e_rdy;
            logic [DW-1:0] d;
            logic [AW-1:0] s;
            logic [DW-1:0] mx;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 7) == 0) ? ONES : {$urandom, $urandom};
            drive(v, d, c, r);
            e_rdy = !(m_valid && !r);
            chk_out($sformatf("rnd[%0d]", n), e_rdy, m_valid, m_sum, m_max);
            if (m_valid && r) m_valid = 1'b0;
            if (c) begin
                blk.delete();
            end else if (v && e_rdy) begin
                blk.push_back(d);
                if (blk.size() == BL) begin
                    s  = '0;
                    mx = '0;
                    foreach (blk[j]) begin
                        s = s + AW'(blk[j]);
                        if (blk[j] > mx) mx = blk[j];
                    end
                    m_sum   = s;
                    m_max   = mx;
                    m_valid = 1'b1;
                    blk.delete();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
